// File: rtl/sisc_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/mem/writeback controller for the SISC datapath.
// Define SISC_CTRL_WAITSTATE_EN to make LOD/STR hold in MEM until dm_ack, with timeout to FAULT.
module sisc_ctrl_fsm #(
  parameter int                OP_W     = 4,
  parameter int                CC_W     = 4,
  parameter logic [CC_W-1:0]   IMM_MODE = CC_W'(8),
  parameter int                CNT_W    = 16,
  parameter int                WAIT_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic [OP_W-1:0]  opcode,
  input  logic [CC_W-1:0]  mm,
  input  logic [CC_W-1:0]  stat,
  input  logic             stall,
  input  logic             dm_ack,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             mm_sel,
  output logic             dm_we,
  output logic             ir_load,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             br_sel,
  output logic             pc_rst,
  output logic             swap_en,
  output logic [1:0]       alu_op,
  output logic [1:0]       rd_sel,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  // state      | meaning
  // START0/1   | two reset cycles holding the PC in reset
  // FETCH      | load IR, advance PC (held while stall)
  // DECODE     | select register-file read port
  // EXECUTE    | ALU operation, branch resolution
  // MEM        | data-memory access / ALU result write
  // WB         | register write for LOD and SWAP
  // HALT       | absorbing, left only via reset
  // FAULT      | absorbing, data-memory timeout

  typedef enum logic [3:0] {
    ST_START0, ST_START1, ST_FETCH, ST_DECODE, ST_EXECUTE,
    ST_MEM, ST_WB, ST_HALT, ST_FAULT
  } state_t;

  localparam logic [OP_W-1:0] OP_NOOP = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LOD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_STR  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SWAP = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BRA  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BRR  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ALU  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_HLT  = {OP_W{1'b1}};

  state_t state, state_nxt;
  logic   is_imm, mm_zero, cond_hit, br_taken, retire;

  assign is_imm   = (mm == IMM_MODE);
  assign mm_zero  = (mm == '0);
  assign cond_hit = ((mm & stat) != '0);

  always_comb begin
    br_taken = 1'b0;
    case (opcode)
      OP_BRA, OP_BRR: br_taken = cond_hit;
      OP_BNE:         br_taken = !cond_hit;
      default:        br_taken = 1'b0;
    endcase
  end

`ifdef SISC_CTRL_WAITSTATE_EN
  localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  logic [WAIT_W-1:0] wait_cnt;
  logic              dm_access;
  assign dm_access = (opcode == OP_LOD) || (opcode == OP_STR);
`else
  logic unused_cfg;
  assign unused_cfg = dm_ack ^ (WAIT_MAX == 0);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_START0:  state_nxt = ST_START1;
      ST_START1:  state_nxt = ST_FETCH;
      ST_FETCH:   state_nxt = stall ? ST_FETCH : ST_DECODE;
      ST_DECODE:  state_nxt = (opcode == OP_HLT) ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE: begin
        case (opcode)
          OP_ALU, OP_LOD, OP_STR, OP_SWAP: state_nxt = ST_MEM;
          default:                         state_nxt = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if ((opcode == OP_LOD) || (opcode == OP_SWAP)) state_nxt = ST_WB;
        else                                           state_nxt = ST_FETCH;
`ifdef SISC_CTRL_WAITSTATE_EN
        // Hold in MEM until the memory acknowledges; the terminal count gives up.
        if (dm_access && !dm_ack)
          state_nxt = (wait_cnt == '0) ? ST_FAULT : ST_MEM;
`endif
      end
      ST_WB:      state_nxt = ST_FETCH;
      ST_HALT:    state_nxt = ST_HALT;
      ST_FAULT:   state_nxt = ST_FAULT;
      default:    state_nxt = ST_START0;
    endcase
  end

  assign retire = (state_nxt == ST_FETCH) &&
                  ((state == ST_EXECUTE) || (state == ST_MEM) || (state == ST_WB));

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state   <= ST_START0;
      retired <= '0;
`ifdef SISC_CTRL_WAITSTATE_EN
      wait_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (retire) retired <= retired + CNT_W'(1);
`ifdef SISC_CTRL_WAITSTATE_EN
      if ((state != ST_MEM) && (state_nxt == ST_MEM))
        wait_cnt <= WAIT_W'(WAIT_MAX - 1);
      else if ((state == ST_MEM) && (wait_cnt != '0))
        wait_cnt <= wait_cnt - WAIT_W'(1);
`endif
    end
  end

  // Strobes decode directly from state so a falling rst_f kills them at once.
  always_comb begin
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    mm_sel   = 1'b0;
    dm_we    = 1'b0;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_rst   = 1'b0;
    swap_en  = 1'b0;
    alu_op   = 2'b00;
    rd_sel   = 2'b00;
    case (state)
      ST_START0, ST_START1: pc_rst = 1'b1;
      ST_FETCH: begin
        ir_load  = !stall;
        pc_write = !stall;
      end
      ST_DECODE: begin
        if ((opcode == OP_LOD) || ((opcode == OP_ALU) && is_imm)) rd_sel = 2'b01;
        else if (opcode == OP_SWAP)                              rd_sel = 2'b10;
      end
      ST_EXECUTE: begin
        case (opcode)
          OP_ALU: alu_op = is_imm ? 2'b01 : 2'b00;
          OP_LOD, OP_STR: begin
            alu_op = mm_zero ? 2'b01 : 2'b00;
            mm_sel = is_imm;
          end
          OP_SWAP: begin
            swap_en = 1'b1;
            rd_sel  = 2'b10;
            rf_we   = 1'b1;
          end
          OP_BRA, OP_BRR, OP_BNE: begin
            alu_op = 2'b10;
            if (br_taken) begin
              pc_sel   = 1'b1;
              pc_write = 1'b1;
              br_sel   = (opcode != OP_BRR);
            end
          end
          default: alu_op = 2'b00;
        endcase
      end
      ST_MEM: begin
        case (opcode)
          OP_ALU:  rf_we = 1'b1;
          OP_STR:  dm_we = 1'b1;
          OP_LOD:  wb_sel = 1'b1;
          OP_SWAP: begin
            swap_en = 1'b1;
            rd_sel  = 2'b10;
          end
          default: rf_we = 1'b0;
        endcase
      end
      ST_WB: begin
        if (opcode == OP_LOD) begin
          rf_we  = 1'b1;
          wb_sel = 1'b1;
        end else if (opcode == OP_SWAP) begin
          rf_we   = 1'b1;
          swap_en = 1'b1;
        end
      end
      default: rf_we = 1'b0;
    endcase
  end

  assign halted = (state == ST_HALT);
`ifdef SISC_CTRL_WAITSTATE_EN
  assign fault = (state == ST_FAULT);
`else
  assign fault = 1'b0;
`endif

  logic unused_op;
  assign unused_op = (opcode == OP_NOOP);

endmodule

// File: tb/tb_sisc_ctrl_fsm.sv
// Directed scoreboard bench for sisc_ctrl_fsm; expected strobes are queued per cycle and
// checked mid-cycle. Wait-state checks run when SISC_CTRL_WAITSTATE_EN is defined.
module tb_sisc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_f;
  logic [3:0]  opcode, mm, stat;
  logic        stall, dm_ack;
  logic        rf_we, wb_sel, mm_sel, dm_we, ir_load, pc_write, pc_sel, br_sel, pc_rst, swap_en;
  logic [1:0]  alu_op, rd_sel;
  logic        halted, fault;
  logic [15:0] retired;

  sisc_ctrl_fsm dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
    .stall(stall), .dm_ack(dm_ack),
    .rf_we(rf_we), .wb_sel(wb_sel), .mm_sel(mm_sel), .dm_we(dm_we),
    .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel), .br_sel(br_sel),
    .pc_rst(pc_rst), .swap_en(swap_en), .alu_op(alu_op), .rd_sel(rd_sel),
    .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] M_HALT  = 16'h8000, M_FAULT = 16'h4000, M_PCRST = 16'h2000,
                          M_IRL   = 16'h1000, M_PCW   = 16'h0800, M_PCSEL = 16'h0400,
                          M_BRSEL = 16'h0200, M_RFWE  = 16'h0100, M_WBSEL = 16'h0080,
                          M_MMSEL = 16'h0040, M_DMWE  = 16'h0020, M_SWAP  = 16'h0010;

  logic [15:0] o_vec;
  assign o_vec = {halted, fault, pc_rst, ir_load, pc_write, pc_sel, br_sel,
                  rf_we, wb_sel, mm_sel, dm_we, swap_en, alu_op, rd_sel};

  typedef struct {
    string       tag;
    logic [15:0] o;
    logic [15:0] r;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic end_req = 1'b0;
  logic end_ack = 1'b0;

  function automatic logic [15:0] ov(input logic [15:0] bits, input logic [1:0] ao,
                                     input logic [1:0] rs);
    return bits | {12'b0, ao, rs};
  endfunction

  // Push the expectation for the current cycle, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [15:0] o, input logic [15:0] r);
    exp_t e;
    e.tag = tag;
    e.o   = o;
    e.r   = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      assert (o_vec === e.o) else begin
        n_err++;
        $error("FAIL %s strobes: got %h expected %h", e.tag, o_vec, e.o);
      end
      n_cmp++;
      assert (retired === e.r) else begin
        n_err++;
        $error("FAIL %s retired: got %0d expected %0d", e.tag, retired, e.r);
      end
    end else if (end_req && !end_ack) begin
      n_cmp++;
      assert (sb.size() === 0) else begin
        n_err++;
        $error("FAIL drain: got %0d left expected 0", sb.size());
      end
      end_ack = 1'b1;
    end
  end

  initial begin
    rst_f = 1'b0; opcode = 4'd0; mm = 4'd0; stat = 4'd0; stall = 1'b0; dm_ack = 1'b0;
    @(posedge clk); #1;
    cyc("rst_hold", M_PCRST, 16'd0);
    rst_f = 1'b1;
    cyc("start0", M_PCRST, 16'd0);
    cyc("start1", M_PCRST, 16'd0);

    opcode = 4'd8; mm = 4'h8; stat = 4'h0;
    cyc("alu_fetch",  M_IRL | M_PCW, 16'd0);
    cyc("alu_decode", ov(16'h0, 2'b00, 2'b01), 16'd0);
    cyc("alu_exec",   ov(16'h0, 2'b01, 2'b00), 16'd0);
    cyc("alu_mem",    M_RFWE, 16'd0);

    opcode = 4'd6; mm = 4'b0010; stat = 4'b0000;
    cyc("bne_t_fetch",  M_IRL | M_PCW, 16'd1);
    cyc("bne_t_decode", 16'h0, 16'd1);
    cyc("bne_t_exec",   ov(M_PCSEL | M_PCW | M_BRSEL, 2'b10, 2'b00), 16'd1);

    stat = 4'b0010;
    cyc("bne_n_fetch",  M_IRL | M_PCW, 16'd2);
    cyc("bne_n_decode", 16'h0, 16'd2);
    cyc("bne_n_exec",   ov(16'h0, 2'b10, 2'b00), 16'd2);

    opcode = 4'd5; mm = 4'b0110; stat = 4'b0100;
    cyc("brr_fetch",  M_IRL | M_PCW, 16'd3);
    cyc("brr_decode", 16'h0, 16'd3);
    cyc("brr_exec",   ov(M_PCSEL | M_PCW, 2'b10, 2'b00), 16'd3);

    opcode = 4'd1; mm = 4'h0; stat = 4'h0; stall = 1'b1;
    for (int i = 0; i < 3; i++) cyc("lod_stall", 16'h0, 16'd4);
    stall = 1'b0;
    cyc("lod_fetch",  M_IRL | M_PCW, 16'd4);
    cyc("lod_decode", ov(16'h0, 2'b00, 2'b01), 16'd4);
    cyc("lod_exec",   ov(16'h0, 2'b01, 2'b00), 16'd4);
    dm_ack = 1'b1;
    cyc("lod_mem",    M_WBSEL, 16'd4);
    dm_ack = 1'b0;
    cyc("lod_wb",     M_RFWE | M_WBSEL, 16'd4);

    opcode = 4'd2; mm = 4'h8;
    cyc("str_fetch",  M_IRL | M_PCW, 16'd5);
    cyc("str_decode", 16'h0, 16'd5);
    cyc("str_exec",   M_MMSEL, 16'd5);
`ifdef SISC_CTRL_WAITSTATE_EN
    for (int i = 0; i < 3; i++) cyc("str_wait", M_DMWE, 16'd5);
    dm_ack = 1'b1;
    cyc("str_ack", M_DMWE, 16'd5);
    dm_ack = 1'b0;
`else
    cyc("str_mem", M_DMWE, 16'd5);
`endif

    opcode = 4'd3; mm = 4'h0;
    cyc("swap_fetch",  M_IRL | M_PCW, 16'd6);
    cyc("swap_decode", ov(16'h0, 2'b00, 2'b10), 16'd6);
    cyc("swap_exec",   ov(M_SWAP | M_RFWE, 2'b00, 2'b10), 16'd6);
    cyc("swap_mem",    ov(M_SWAP, 2'b00, 2'b10), 16'd6);
    cyc("swap_wb",     M_RFWE | M_SWAP, 16'd6);

    opcode = 4'd7;
    cyc("unk_fetch",  M_IRL | M_PCW, 16'd7);
    cyc("unk_decode", 16'h0, 16'd7);
    cyc("unk_exec",   16'h0, 16'd7);

    opcode = 4'hF;
    cyc("hlt_fetch",  M_IRL | M_PCW, 16'd8);
    cyc("hlt_decode", 16'h0, 16'd8);
    for (int i = 0; i < 11; i++) cyc("halt_hold", M_HALT, 16'd8);
    rst_f = 1'b0;
    cyc("halt_rst", M_PCRST, 16'd0);
    rst_f = 1'b1;
    cyc("re_start0", M_PCRST, 16'd0);
    cyc("re_start1", M_PCRST, 16'd0);

    opcode = 4'd8; mm = 4'h0;
    cyc("abort_fetch",  M_IRL | M_PCW, 16'd0);
    cyc("abort_decode", 16'h0, 16'd0);
    cyc("abort_exec",   16'h0, 16'd0);
    rst_f = 1'b0;
    cyc("abort_mem", M_PCRST, 16'd0);
    rst_f = 1'b1;
    cyc("ab_start0", M_PCRST, 16'd0);
    cyc("ab_start1", M_PCRST, 16'd0);

`ifdef SISC_CTRL_WAITSTATE_EN
    opcode = 4'd2; mm = 4'h0; dm_ack = 1'b0;
    cyc("to_fetch",  M_IRL | M_PCW, 16'd0);
    cyc("to_decode", 16'h0, 16'd0);
    cyc("to_exec",   ov(16'h0, 2'b01, 2'b00), 16'd0);
    for (int i = 0; i < 8; i++) cyc("to_wait", M_DMWE, 16'd0);
    for (int i = 0; i < 3; i++) cyc("to_fault", M_FAULT, 16'd0);
`else
    dm_ack = 1'b1;
    cyc("final_fetch", M_IRL | M_PCW, 16'd0);
    dm_ack = 1'b0;
`endif

    end_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
